// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//
// Fetch-stage PC generator with a direct-mapped branch target buffer and a
// 2-bit saturating-counter direction predictor per entry. The fetch PC is
// predicted with zero latency from the BTB. Branch/jump resolutions come back
// from EXE. A wrong direction or a wrong taken target raises a combinational
// flush and redirects the PC on the next rising edge.
//
// Ports:
//   clk             rising-edge clock
//   nrst            synchronous, active-low reset
//   stall           hold the fetch PC (a redirect still wins)
//   pc              registered fetch PC
//   pred_taken      BTB hit with counter in a taken state
//   pred_target     BTB target when predicted taken, else pc+4
//   res_valid       EXE resolves a branch/jump this cycle (one cycle each)
//   res_pc          PC of the resolving instruction
//   res_taken       actual direction
//   res_target      actual taken target
//   res_pred_taken  prediction carried down the pipe with the instruction
//   res_pred_target predicted target carried down the pipe
//   flush           squash IF/ID and ID/EX (combinational, same cycle)
//   br_cnt          number of resolutions seen (wraps)
//   mispred_cnt     number of mispredictions seen (wraps)

module pc_predict_unit #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            flush,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int              IW      = $clog2(BTB_DEPTH);
  localparam int              TW      = XLEN - IW - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // BTB storage, one packed slice per entry
  logic [BTB_DEPTH-1:0]           btb_valid;
  logic [BTB_DEPTH-1:0][TW-1:0]   btb_tag;
  logic [BTB_DEPTH-1:0][XLEN-1:0] btb_target;
  logic [BTB_DEPTH-1:0][1:0]      btb_ctr;

  logic [IW-1:0]   f_idx;
  logic [TW-1:0]   f_tag;
  logic            f_hit;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tag;
  logic            r_hit;
  logic            mispredict;
  logic [XLEN-1:0] next_pc;

  // Fetch-side lookup; reads the stored contents, so an update to the same
  // entry in this cycle is not seen until the next cycle.
  always_comb begin
    f_idx       = pc[IW+1:2];
    f_tag       = pc[XLEN-1:IW+2];
    f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    pred_taken  = f_hit && btb_ctr[f_idx][1];
    pred_target = pred_taken ? btb_target[f_idx] : pc + PC_STEP;
  end

  // Resolution-side lookup and mispredict detection. A taken branch whose
  // direction was right but whose target differs is still a mispredict.
  always_comb begin
    r_idx      = res_pc[IW+1:2];
    r_tag      = res_pc[XLEN-1:IW+2];
    r_hit      = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
    mispredict = res_valid &&
                 ((res_taken != res_pred_taken) ||
                  (res_taken && (res_target != res_pred_target)));
    flush      = mispredict;
  end

  // Next-PC selection: a redirect beats a stall, otherwise follow prediction.
  always_comb begin
    next_pc = pred_target;
    if (mispredict) begin
      next_pc = res_taken ? res_target : res_pc + PC_STEP;
    end else if (stall) begin
      next_pc = pc;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // BTB training. Counters start weakly not-taken; a fresh allocation starts
  // weakly taken so the next fetch of the branch follows the learned target.
  // A taken miss evicts whatever lives in the slot.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (res_valid) begin
      if (r_hit) begin
        if (res_taken) begin
          btb_target[r_idx] <= res_target;
          if (btb_ctr[r_idx] != 2'b11) begin
            btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
          end
        end else if (btb_ctr[r_idx] != 2'b00) begin
          btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
        end
      end else if (res_taken) begin
        btb_valid[r_idx]  <= 1'b1;
        btb_tag[r_idx]    <= r_tag;
        btb_target[r_idx] <= res_target;
        btb_ctr[r_idx]    <= 2'b10;
      end
    end
  end

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (!nrst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_valid) begin
        br_cnt <= br_cnt + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit
//
// Self-checking bench for pc_predict_unit with XLEN=32, BTB_DEPTH=16 and
// RESET_PC=0x100. Each driven cycle pushes the expected next PC into a
// scoreboard queue; it is popped and compared after the clock edge. flush,
// predictions and counters are compared against hand-derived constants.

module tb_pc_predict_unit;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        stall = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = '0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  typedef struct {
    string       tag;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_predict_unit #(
    .XLEN(32),
    .BTB_DEPTH(16),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .stall(stall),
    .pc(pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .res_valid(res_valid),
    .res_pc(res_pc),
    .res_taken(res_taken),
    .res_target(res_target),
    .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target),
    .flush(flush),
    .br_cnt(br_cnt),
    .mispred_cnt(mispred_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check flush, queue the
  // expected next PC and compare it once the rising edge has passed.
  task automatic applyStimulus(input string tag, input logic st, input logic rv,
                               input logic [31:0] rpc, input logic rt,
                               input logic [31:0] rtgt, input logic rpt,
                               input logic [31:0] rptgt, input logic exp_flush,
                               input logic [31:0] exp_pc);
    exp_t e;
    @(negedge clk);
    stall           = st;
    res_valid       = rv;
    res_pc          = rpc;
    res_taken       = rt;
    res_target      = rtgt;
    res_pred_taken  = rpt;
    res_pred_target = rptgt;
    #1;
    checkOutput({tag, ".flush"}, {63'd0, flush}, {63'd0, exp_flush});
    e.tag = tag;
    e.pc  = exp_pc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.sb: got empty queue, expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, ".pc"}, {32'd0, pc}, {32'd0, e.pc});
    end
  endtask

  // Idle cycle: no resolution, no stall
  task automatic idle(input string tag, input logic [31:0] exp_pc);
    applyStimulus(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, exp_pc);
  endtask

  // Prediction for the current fetch PC
  task automatic checkPred(input string tag, input logic exp_taken,
                           input logic [31:0] exp_target);
    checkOutput({tag, ".pred_taken"}, {63'd0, pred_taken}, {63'd0, exp_taken});
    checkOutput({tag, ".pred_target"}, {32'd0, pred_target}, {32'd0, exp_target});
  endtask

  task automatic checkCounters(input string tag, input logic [31:0] exp_br,
                               input logic [31:0] exp_mis);
    checkOutput({tag, ".br_cnt"}, {32'd0, br_cnt}, {32'd0, exp_br});
    checkOutput({tag, ".mispred_cnt"}, {32'd0, mispred_cnt}, {32'd0, exp_mis});
  endtask

  // Redirect to 0x108 via a not-taken mispredict of a branch at 0x104 that
  // misses in the BTB, so no entry is touched.
  task automatic redirectTo108(input string tag);
    applyStimulus(tag, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h999, 1'b1, 32'h108);
  endtask

  // Main sequence
  initial begin
    // Reset held for two cycles
    nrst = 1'b0;
    idle("rst0", RST_PC);
    idle("rst1", RST_PC);
    checkPred("rst", 1'b0, 32'h104);
    checkCounters("rst", 32'd0, 32'd0);
    nrst = 1'b1;

    // Sequential fetch
    idle("run0", 32'h104);
    idle("run1", 32'h108);
    idle("run2", 32'h10C);

    // First-seen taken branch at 0x108 allocates and redirects
    applyStimulus("alloc", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0, 32'h10C, 1'b1, 32'h100);
    checkCounters("alloc", 32'd1, 32'd1);
    checkPred("at100", 1'b0, 32'h104);
    idle("run3", 32'h104);
    idle("run4", 32'h108);
    checkPred("hit108", 1'b1, 32'h100);

    // Three correctly predicted takens saturate the counter
    applyStimulus("tk1", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
    applyStimulus("tk2", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h104);
    applyStimulus("tk3", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h108);
    checkPred("ctr3", 1'b1, 32'h100);

    // Not taken: mispredict, counter 3 -> 2, still predicting taken
    applyStimulus("nt1", 1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h10C);
    checkPred("at10C", 1'b0, 32'h110);
    redirectTo108("redir1");
    checkPred("ctr2", 1'b1, 32'h100);

    // Second not taken: counter 2 -> 1, prediction falls back to pc+4
    applyStimulus("nt2", 1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h10C);
    redirectTo108("redir2");
    checkPred("ctr1", 1'b0, 32'h10C);
    checkCounters("ctrpath", 32'd8, 32'd5);

    // Stall holds the PC; a redirect during stall still moves it
    for (int i = 0; i < 4; i++) begin
      applyStimulus("stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108);
    end
    applyStimulus("stallredir", 1'b1, 1'b1, 32'h1F0, 1'b1, 32'h200, 1'b0, 32'h1F4, 1'b1, 32'h200);

    // Alias: 0x148 shares the index of 0x108 and evicts it
    applyStimulus("alias", 1'b0, 1'b1, 32'h148, 1'b1, 32'h400, 1'b0, 32'h14C, 1'b1, 32'h400);
    redirectTo108("redir3");
    checkPred("evicted", 1'b0, 32'h10C);

    // Re-learn 0x108, bring it to counter 3, then change its target
    applyStimulus("realloc", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0, 32'h10C, 1'b1, 32'h100);
    applyStimulus("tk4", 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h104);
    idle("run5", 32'h108);
    checkPred("pre_tgt", 1'b1, 32'h100);
    applyStimulus("newtgt", 1'b0, 1'b1, 32'h108, 1'b1, 32'h180, 1'b1, 32'h100, 1'b1, 32'h180);
    redirectTo108("redir4");
    checkPred("post_tgt", 1'b1, 32'h180);
    checkCounters("tgt", 32'd15, 32'd11);

    // pc+4 wraps at the top of the address space
    applyStimulus("towrap", 1'b0, 1'b1, 32'h104, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h108, 1'b1,
                  32'hFFFF_FFFC);
    checkPred("wrap", 1'b0, 32'h0);
    idle("wrapped", 32'h0);
    checkCounters("wrap", 32'd16, 32'd12);

    // Reset mid-operation with a resolution pending: flush still follows
    // the inputs, but everything is cleared on that edge
    nrst = 1'b0;
    applyStimulus("midrst", 1'b0, 1'b1, 32'h104, 1'b1, 32'h500, 1'b0, 32'h108, 1'b1, RST_PC);
    nrst = 1'b1;
    checkCounters("midrst", 32'd0, 32'd0);
    checkPred("clr100", 1'b0, 32'h104);
    idle("run6", 32'h104);
    checkPred("clr104", 1'b0, 32'h108);
    idle("run7", 32'h108);
    checkPred("clr108", 1'b0, 32'h10C);
    idle("run8", 32'h10C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised fetch-stage PC generator with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating-counter predictor. It replaces the fixed-width, non-predicting PC register logic of the pipelined RV64 core. It predicts next-PC at fetch, accepts branch/jump resolution from EXE, and issues a redirect plus pipeline flush on mispredict. Stall support and performance counters are included.

## Interface
Parameters:
- XLEN, 32, width of PC and targets
- BTB_DEPTH, 16, BTB entries; power of 2, ≥2
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, synchronous, active-low
- stall  in  1  hold PC (hazard stall)
- pc  out  XLEN  current fetch PC (registered)
- pred_taken  out  1  prediction for current pc
- pred_target  out  XLEN  predicted target for current pc (BTB target, else pc+4)
- res_valid  in  1  EXE resolving a branch/jump this cycle
- res_pc  in  XLEN  PC of resolving instruction
- res_taken  in  1  actual outcome (JAL/JALR always 1)
- res_target  in  XLEN  actual taken target
- res_pred_taken  in  1  prediction carried down the pipe with the instruction
- res_pred_target  in  XLEN  predicted target carried down the pipe
- flush  out  1  squash IF/ID and ID/EX this cycle (combinational)
- br_cnt  out  32  resolved branch count
- mispred_cnt  out  32  mispredict count

## Operation
- Index = pc[IW+1:2], where IW = log2(BTB_DEPTH). Tag = pc[XLEN-1:IW+2]. Each entry holds valid, tag, target[XLEN], ctr[1:0].
- Lookup is combinational on pc. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? entry.target : pc+4.
- mispredict = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target)). flush = mispredict.
- Next-PC priority:
  - reset → RESET_PC
  - mispredict → (res_taken ? res_target : res_pc+4)
  - stall → pc
  - otherwise pred_target
- Redirect overrides stall.
- BTB update when res_valid (independent of stall), on the entry indexed by res_pc:
  - hit: ctr increments (saturate at 3) if taken, decrements (saturate at 0) if not. Target is written with res_target if taken.
  - miss and taken: allocate. valid=1, tag and target written, ctr=2'b10. Any existing entry is overwritten.
  - miss and not taken: no change.
- Counters: br_cnt +1 per res_valid; mispred_cnt +1 per mispredict. Both wrap modulo 2^32.
- All PC arithmetic is modulo 2^XLEN. pc+4 wraps silently.

## Timing
- Reset: pc=RESET_PC, all valid=0, all ctr=2'b01, br_cnt=0, mispred_cnt=0. pred_taken=0 and pred_target=RESET_PC+4 follow combinationally. flush is 0 unless res_valid is asserted during reset; res_* is ignored during reset.
- Reset mid-operation: all state is cleared on that edge. Pending resolutions are dropped.
- pc updates every rising edge per the priority above. Prediction latency is 0 cycles; redirect latency is 1 edge, so the corrected pc is visible the cycle after res_valid.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. There is no bypass.
- The EXE stage must present res_* for exactly one cycle per resolving instruction, with no handshake; a held res_valid counts again.
- flush is asserted in the same cycle as res_valid. Pipeline registers squash on the same edge the redirect loads.

## Test plan
- Reset with RESET_PC=0x100, nrst=0 for 2 cycles → pc=0x100, pred_taken=0, counters=0. Then 3 free-run cycles → pc=0x104, 0x108, 0x10C.
- Branch at 0x108 first seen taken (res_pred_taken=0, res_target=0x100) → flush=1, next pc=0x100, mispred_cnt=1. On the next fetch of 0x108 → pred_taken=1, pred_target=0x100.
- Counter path: taken ×3 on 0x108 (ctr 3), then not taken → ctr=2, still predicts taken. A second not taken → ctr=1, prediction=0, pc+4 used. A mispredict flush is required on the first not-taken.
- stall=1 for 4 cycles → pc held constant. Apply res_valid mispredict during stall (target 0x200) → pc=0x200 next cycle despite stall.
- Alias: with BTB_DEPTH=16, 0x108 is allocated; resolve taken branch 0x148 (same index, different tag) → entry replaced. Fetch of 0x108 → pred_taken=0.
- Target change: hit entry with ctr=3 predicting 0x100 resolves taken to 0x180 → mispredict, flush=1, pc=0x180, BTB target updated to 0x180.
